// File: rtl/program_loader.sv
// program_loader
//   Host-side companion to the YASAC control unit. Accepts a byte stream
//   (length byte, then 16-bit words high byte first), writes the words into
//   program memory while holding the CPU in reset, then starts the CPU and
//   counts the cycles it spends busy until RDY returns, or aborts on timeout.
//
// Ports
//   CLK, RESET_N        clock (rising edge), synchronous active-low reset
//   HOST_VALID/DATA     host byte stream; HOST_READY accepts a byte
//   CLEAR               acknowledge result, DONE -> IDLE
//   PMEM_WE/ADDR/WDATA  program memory write port
//   CPU_RESET/START/RDY control unit handshake
//   DONE, TIMED_OUT     run finished / last run aborted by timeout
//   RUN_CYCLES          CPU_RDY=0 cycles counted in the last run
//   STATE_OUT           FSM state, for debug
module program_loader #(
  parameter int unsigned INSTR_WIDTH     = 16,
  parameter int unsigned PROG_ADDR_WIDTH = 8,
  parameter logic [15:0] TIMEOUT         = 16'hFFFF
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       HOST_VALID,
  input  logic [7:0]                 HOST_DATA,
  output logic                       HOST_READY,
  input  logic                       CLEAR,
  output logic                       PMEM_WE,
  output logic [PROG_ADDR_WIDTH-1:0] PMEM_ADDR,
  output logic [INSTR_WIDTH-1:0]     PMEM_WDATA,
  output logic                       CPU_RESET,
  output logic                       CPU_START,
  input  logic                       CPU_RDY,
  output logic                       DONE,
  output logic                       TIMED_OUT,
  output logic [15:0]                RUN_CYCLES,
  output logic [2:0]                 STATE_OUT
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BYTE_HI = 3'd1,
    S_BYTE_LO = 3'd2,
    S_WRITE   = 3'd3,
    S_START   = 3'd4,
    S_RUN     = 3'd5,
    S_ABORT   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // Word count compared one bit wider than the address so that a
  // 255-word load ends on the count rather than wrapping.
  localparam int unsigned CW = (PROG_ADDR_WIDTH > 8) ? PROG_ADDR_WIDTH + 1 : 9;

  state_t                     state, state_nxt;
  logic [7:0]                 nwords;
  logic [PROG_ADDR_WIDTH-1:0] wcnt;
  logic [7:0]                 hi, lo;
  logic [15:0]                run_cycles;
  logic                       timed_out;

  logic [CW-1:0]              wcnt_inc;
  logic                       last_word;
  logic                       timeout_hit;

  assign wcnt_inc    = CW'(wcnt) + CW'(1);
  assign last_word   = (wcnt_inc == CW'(nwords));
  assign timeout_hit = (TIMEOUT != 16'd0) && (run_cycles == TIMEOUT);

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    HOST_READY = 1'b0;
    PMEM_WE    = 1'b0;
    CPU_RESET  = 1'b0;
    CPU_START  = 1'b0;
    DONE       = 1'b0;
    case (state)
      S_IDLE: begin
        HOST_READY = 1'b1;
        CPU_RESET  = 1'b1;
        if (HOST_VALID) state_nxt = (HOST_DATA == 8'd0) ? S_START : S_BYTE_HI;
      end
      S_BYTE_HI: begin
        HOST_READY = 1'b1;
        CPU_RESET  = 1'b1;
        if (HOST_VALID) state_nxt = S_BYTE_LO;
      end
      S_BYTE_LO: begin
        HOST_READY = 1'b1;
        CPU_RESET  = 1'b1;
        if (HOST_VALID) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        PMEM_WE   = 1'b1;
        CPU_RESET = 1'b1;
        state_nxt = last_word ? S_START : S_BYTE_HI;
      end
      S_START: begin
        // START is only raised once the control unit reports ready.
        CPU_START = CPU_RDY;
        if (CPU_RDY) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (CPU_RDY)          state_nxt = S_DONE;
        else if (timeout_hit) state_nxt = S_ABORT;
      end
      S_ABORT: begin
        CPU_RESET = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        DONE = 1'b1;
        if (CLEAR) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      nwords     <= '0;
      wcnt       <= '0;
      hi         <= '0;
      lo         <= '0;
      run_cycles <= '0;
      timed_out  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (HOST_VALID) begin
            nwords <= HOST_DATA;
            wcnt   <= '0;
          end
        end
        S_BYTE_HI: if (HOST_VALID) hi <= HOST_DATA;
        S_BYTE_LO: if (HOST_VALID) lo <= HOST_DATA;
        S_WRITE:   wcnt <= wcnt_inc[PROG_ADDR_WIDTH-1:0];
        S_START: begin
          run_cycles <= '0;
          timed_out  <= 1'b0;
        end
        S_RUN: begin
          if (!CPU_RDY && !timeout_hit && (run_cycles != '1))
            run_cycles <= run_cycles + 16'd1;
        end
        S_ABORT: timed_out <= 1'b1;
        default: ;
      endcase
    end
  end

  assign PMEM_ADDR  = (state == S_WRITE) ? wcnt : '0;
  assign PMEM_WDATA = (state == S_WRITE) ? INSTR_WIDTH'({hi, lo}) : '0;
  assign RUN_CYCLES = run_cycles;
  assign TIMED_OUT  = timed_out;
  assign STATE_OUT  = state;

endmodule
